unified_memory_responder: RTL and testbench

Single-port unified instruction/data memory that answers the fetch unit's memory requests. It is the responder side of the Addr/RAM_OUT interface. It accepts one word-aligned read or write per transaction and inserts a configurable number of wait states. It signals completion with a one-cycle ready pulse and flags bad addresses so the control unit can raise an exception and capture EPC.

---
 rtl/unified_memory_responder_if.sv | 25 ++
 rtl/unified_memory_responder.sv | 115 +++++++++++
 tb/tb_unified_memory_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/unified_memory_responder_if.sv
// Request/response bundle between the fetch unit and the unified memory.
// master: fetch unit (drives Addr/WD/MEM_RD/MEM_WR); slave: memory responder.
interface unified_memory_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();
    logic [ADDRESS_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0]    WD;
    logic                     MEM_RD;
    logic                     MEM_WR;
    logic [DATA_WIDTH-1:0]    RAM_OUT;
    logic                     MEM_READY;
    logic                     ADDR_ERR;
    logic                     BUSY;

    modport master (
        output Addr, WD, MEM_RD, MEM_WR,
        input  RAM_OUT, MEM_READY, ADDR_ERR, BUSY
    );

    modport slave (
        input  Addr, WD, MEM_RD, MEM_WR,
        output RAM_OUT, MEM_READY, ADDR_ERR, BUSY
    );
endinterface

// File: rtl/unified_memory_responder.sv
// Unified instruction/data memory with configurable wait states.
// Ports: CLK, RST (sync active-low), bus (slave): Addr, WD, MEM_RD, MEM_WR in;
//        RAM_OUT (registered read data), MEM_READY, ADDR_ERR, BUSY out.
module unified_memory_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    unified_memory_responder_if.slave   bus
);
    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT =
        (ADDRESS_WIDTH+1)'(DEPTH_WORDS * 4);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic                     wr_q;
    logic [DATA_WIDTH-1:0]    ram_out_q;

    logic [DATA_WIDTH-1:0]    mem [DEPTH_WORDS];

    logic                     req;
    logic                     bad;
    logic                     is_rd;
    logic [IDXW-1:0]          rd_idx;
    logic [IDXW-1:0]          wr_idx;
    logic                     rd_fire;

    assign req = bus.MEM_RD | bus.MEM_WR;
    assign bad = (bus.Addr[1:0] != 2'b00)
               | ({1'b0, bus.Addr} >= ADDR_LIMIT)
               | (bus.MEM_RD & bus.MEM_WR);

    // With zero wait states the read happens on the sampling edge itself,
    // so the index and operation come straight from the bus in IDLE.
    assign is_rd  = (state_q == S_IDLE) ? bus.MEM_RD : ~wr_q;
    assign rd_idx = (state_q == S_IDLE) ? bus.Addr[IDXW+1:2]
                                        : addr_q[IDXW+1:2];
    assign wr_idx = addr_q[IDXW+1:2];

    assign rd_fire = (state_d == S_ACCESS) & (state_q != S_ACCESS) & is_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bad)
                        state_d = S_ERROR;
                    else if (WAIT_CYCLES > 0)
                        state_d = S_WAIT;
                    else
                        state_d = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wd_q      <= '0;
            wr_q      <= 1'b0;
            ram_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req) begin
                addr_q <= bus.Addr;
                wd_q   <= bus.WD;
                wr_q   <= bus.MEM_WR;
            end
            if (rd_fire)
                ram_out_q <= mem[rd_idx];
        end
    end

    // Array has no reset; a reset in ACCESS aborts the pending write.
    always_ff @(posedge CLK) begin
        if (RST && state_q == S_ACCESS && wr_q)
            mem[wr_idx] <= wd_q;
    end

    assign bus.RAM_OUT   = ram_out_q;
    assign bus.MEM_READY = (state_q == S_ACCESS);
    assign bus.ADDR_ERR  = (state_q == S_ERROR);
    assign bus.BUSY      = (state_q != S_IDLE);
endmodule

// File: tb/tb_unified_memory_responder.sv
// Directed bench for unified_memory_responder (WAIT_CYCLES=2 and =0).
// Ports: none; instantiates two responders sharing clk/rst.
module tb_unified_memory_responder;
    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    unified_memory_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    unified_memory_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    unified_memory_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
        .DEPTH_WORDS(256), .WAIT_CYCLES(2)
    ) u0 (
        .CLK(clk), .RST(rst), .bus(bus0.slave)
    );

    unified_memory_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
        .DEPTH_WORDS(256), .WAIT_CYCLES(0)
    ) u1 (
        .CLK(clk), .RST(rst), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on u0 (2 wait states); inputs are scrambled right
    // after the sampling edge to show they are latched.
    task automatic txn0(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_out);
        bus0.Addr   = addr;
        bus0.WD     = wd;
        bus0.MEM_RD = rd;
        bus0.MEM_WR = wr;
        step();
        bus0.Addr   = 32'h0000_0014;
        bus0.WD     = 32'h5A5A_5A5A;
        bus0.MEM_RD = 1'b0;
        bus0.MEM_WR = 1'b0;
        if (exp_err) begin
            chk({tag, ".c1.busy"}, 32'(bus0.BUSY), 32'd1);
            chk({tag, ".c1.err"}, 32'(bus0.ADDR_ERR), 32'd1);
            chk({tag, ".c1.rdy"}, 32'(bus0.MEM_READY), 32'd0);
            chk({tag, ".c1.out"}, bus0.RAM_OUT, exp_out);
            step();
            chk({tag, ".c2.busy"}, 32'(bus0.BUSY), 32'd0);
            chk({tag, ".c2.err"}, 32'(bus0.ADDR_ERR), 32'd0);
            chk({tag, ".c2.rdy"}, 32'(bus0.MEM_READY), 32'd0);
        end else begin
            chk({tag, ".c1.busy"}, 32'(bus0.BUSY), 32'd1);
            chk({tag, ".c1.rdy"}, 32'(bus0.MEM_READY), 32'd0);
            step();
            chk({tag, ".c2.busy"}, 32'(bus0.BUSY), 32'd1);
            chk({tag, ".c2.rdy"}, 32'(bus0.MEM_READY), 32'd0);
            step();
            chk({tag, ".c3.rdy"}, 32'(bus0.MEM_READY), 32'd1);
            chk({tag, ".c3.err"}, 32'(bus0.ADDR_ERR), 32'd0);
            chk({tag, ".c3.out"}, bus0.RAM_OUT, exp_out);
            step();
            chk({tag, ".c4.rdy"}, 32'(bus0.MEM_READY), 32'd0);
            chk({tag, ".c4.busy"}, 32'(bus0.BUSY), 32'd0);
            chk({tag, ".c4.out"}, bus0.RAM_OUT, exp_out);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst = 1'b0;
        bus0.Addr = '0; bus0.WD = '0; bus0.MEM_RD = 1'b0; bus0.MEM_WR = 1'b0;
        bus1.Addr = '0; bus1.WD = '0; bus1.MEM_RD = 1'b0; bus1.MEM_WR = 1'b0;

        // 1. reset
        step();
        step();
        rst = 1'b1;
        chk("rst.out", bus0.RAM_OUT, 32'h0);
        chk("rst.rdy", 32'(bus0.MEM_READY), 32'd0);
        chk("rst.err", 32'(bus0.ADDR_ERR), 32'd0);
        chk("rst.busy", 32'(bus0.BUSY), 32'd0);
        chk("rst.busy1", 32'(bus1.BUSY), 32'd0);
        step();

        // 2. preload mem[3] then read it back
        txn0("pre_wr_c", 1'b0, 1'b1, 32'h0000_000C, 32'h8C22_0004,
             1'b0, 32'h0);
        txn0("rd_c", 1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h8C22_0004);

        // 3. write then read-after-write
        txn0("wr_10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,
             1'b0, 32'h8C22_0004);
        txn0("rd_10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // 4. rejected requests
        txn0("err_unal", 1'b1, 1'b0, 32'h0000_0006, 32'h0,
             1'b1, 32'hDEAD_BEEF);
        txn0("err_range", 1'b1, 1'b0, 32'h0000_0400, 32'h0,
             1'b1, 32'hDEAD_BEEF);
        txn0("err_both", 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111,
             1'b1, 32'hDEAD_BEEF);
        txn0("rd_10_again", 1'b1, 1'b0, 32'h0000_0010, 32'h0,
             1'b0, 32'hDEAD_BEEF);
        txn0("rd_c_again", 1'b1, 1'b0, 32'h0000_000C, 32'h0,
             1'b0, 32'h8C22_0004);

        // 5. write aborted by reset during WAIT
        txn0("pre_wr_20", 1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_5555,
             1'b0, 32'h8C22_0004);
        bus0.Addr = 32'h0000_0020; bus0.WD = 32'h1234_5678;
        bus0.MEM_WR = 1'b1;
        step();
        bus0.MEM_WR = 1'b0;
        chk("abort.c1.busy", 32'(bus0.BUSY), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort.c2.busy", 32'(bus0.BUSY), 32'd0);
        chk("abort.c2.rdy", 32'(bus0.MEM_READY), 32'd0);
        chk("abort.c2.out", bus0.RAM_OUT, 32'h0);
        step();
        chk("abort.c3.rdy", 32'(bus0.MEM_READY), 32'd0);
        step();
        chk("abort.c4.rdy", 32'(bus0.MEM_READY), 32'd0);
        txn0("rd_20", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hAAAA_5555);

        // 6. zero wait states, read held high continuously
        bus1.Addr = 32'h0; bus1.WD = 32'hCAFE_F00D; bus1.MEM_WR = 1'b1;
        step();
        bus1.MEM_WR = 1'b0;
        chk("w0.wr.rdy", 32'(bus1.MEM_READY), 32'd1);
        chk("w0.wr.out", bus1.RAM_OUT, 32'h0);
        step();
        chk("w0.wr.idle", 32'(bus1.BUSY), 32'd0);
        bus1.MEM_RD = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("w0.rd%0d.rdy", i), 32'(bus1.MEM_READY),
                32'(i % 2));
            chk($sformatf("w0.rd%0d.busy", i), 32'(bus1.BUSY), 32'(i % 2));
            chk($sformatf("w0.rd%0d.out", i), bus1.RAM_OUT, 32'hCAFE_F00D);
        end
        bus1.MEM_RD = 1'b0;
        step();
        step();
        chk("w0.end.busy", 32'(bus1.BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
